// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported, variable-latency memory between
// the instruction-fetch and load/store requesters, one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_len,
    input  logic                  d_unsigned,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [1:0]            m_len,
    output logic                  m_unsigned,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy,
    output logic                  protocol_err
);

    localparam logic [1:0] FETCH_LEN = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t state, state_nxt;
    owner_t owner, last_owner, sel;
    logic   capture;

    // State register; m_req and busy are registered copies of the next-state decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            m_req <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            m_req <= (state_nxt == ISSUE);
            busy  <= (state_nxt != IDLE);
        end
    end

    // Next state and combinational grant; on a tie the owner that did not go last wins
    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        capture   = 1'b0;
        sel       = OWN_FETCH;
        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    capture   = 1'b1;
                    state_nxt = ISSUE;
                    if (if_req && d_req) begin
                        if (last_owner == OWN_DATA) sel = OWN_FETCH;
                        else                        sel = OWN_DATA;
                    end else if (d_req) begin
                        sel = OWN_DATA;
                    end
                    if_gnt = (sel == OWN_FETCH);
                    d_gnt  = (sel == OWN_DATA);
                end
            end
            ISSUE: if (m_ready)  state_nxt = WAIT;
            WAIT:  if (m_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, response routing and sticky protocol error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner        <= OWN_FETCH;
            last_owner   <= OWN_DATA;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_len        <= 2'b00;
            m_unsigned   <= 1'b0;
            if_rvalid    <= 1'b0;
            d_rvalid     <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            protocol_err <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (capture) begin
                owner      <= sel;
                last_owner <= sel;
                if (sel == OWN_DATA) begin
                    m_we       <= d_we;
                    m_addr     <= d_addr;
                    m_wdata    <= d_wdata;
                    m_len      <= d_len;
                    m_unsigned <= d_unsigned;
                end else begin
                    m_we       <= 1'b0;
                    m_addr     <= if_addr;
                    m_wdata    <= '0;
                    m_len      <= FETCH_LEN;
                    m_unsigned <= 1'b0;
                end
            end
            if ((state == WAIT) && m_rvalid) begin
                if (owner == OWN_DATA) begin
                    d_rdata  <= m_rdata;
                    d_rvalid <= 1'b1;
                end else begin
                    if_rdata  <= m_rdata;
                    if_rvalid <= 1'b1;
                end
            end
            if (m_rvalid && (state != WAIT)) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed protocol scenarios, then randomized traffic
// checked by a queue-based scoreboard against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_len;
    logic        m_req, m_we, m_unsigned, m_ready, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_len;
    logic        busy, protocol_err;

    int n_chk  = 0;
    int n_pass = 0;
    bit done   = 0;

    typedef struct {
        bit          is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  len;
        logic        uns;
    } txn_t;

    txn_t        txn_q[$];
    logic [31:0] resp_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_len(d_len), .d_unsigned(d_unsigned), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_len(m_len), .m_unsigned(m_unsigned), .m_ready(m_ready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got timeout/unexpected event, want expected handshake", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h1000 + 32'(4 * $urandom_range(0, 15));
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_len = 2'b00; d_unsigned = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Random fetch requester: holds req until granted
    task automatic gen_fetch(input int n);
        int cnt;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if_addr = rand_addr();
            if_req  = 1'b1;
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!if_gnt && cnt < 500);
            if (!if_gnt) begin fail_now("fetch_gnt_timeout"); if_req = 1'b0; return; end
            @(posedge clk); #1 if_req = 1'b0;
        end
    endtask

    task automatic gen_data(input int n);
        int cnt;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            d_we       = 1'($urandom_range(0, 1));
            d_addr     = rand_addr();
            d_wdata    = $urandom;
            d_len      = 2'($urandom_range(0, 2));
            d_unsigned = 1'($urandom_range(0, 1));
            d_req      = 1'b1;
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!d_gnt && cnt < 500);
            if (!d_gnt) begin fail_now("data_gnt_timeout"); d_req = 1'b0; return; end
            @(posedge clk); #1 d_req = 1'b0;
        end
    endtask

    // Memory model with random accept and response latency
    task automatic responder(input int n);
        int cnt;
        for (int s = 0; s < n; s++) begin
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!m_req && cnt < 1000);
            if (!m_req) begin fail_now("m_req_timeout"); return; end
            @(posedge clk); #1;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            m_ready = 1'b1;
            @(posedge clk); #1 m_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if (m_we) begin
                resp_mem[m_addr] = m_wdata;
                m_rdata = $urandom;
            end else begin
                m_rdata = resp_mem.exists(m_addr) ? resp_mem[m_addr] : init_word(m_addr);
            end
            m_rvalid = 1'b1;
            @(posedge clk); #1 m_rvalid = 1'b0;
        end
    endtask

    // Scoreboard: grants push expected transactions, completions pop and compare
    task automatic monitor();
        bit model_free = 1, last_data = 1, pend_rv = 0, accepted = 0, w;
        int cyc = 0;
        txn_t t;
        logic [31:0] exp_d;
        txn_q.delete();
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_rv) begin
                pend_rv = 0;
                if (txn_q.size() == 0) fail_now("rvalid_without_txn");
                else begin
                    t = txn_q.pop_front();
                    chk("sb_if_rvalid", 32'(if_rvalid), 32'(!t.is_data));
                    chk("sb_d_rvalid", 32'(d_rvalid), 32'(t.is_data));
                    if (t.we) ref_mem[t.addr] = t.wdata;
                    else begin
                        exp_d = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_word(t.addr);
                        if (t.is_data) chk("sb_d_rdata", d_rdata, exp_d);
                        else           chk("sb_if_rdata", if_rdata, exp_d);
                    end
                end
                model_free = 1;
            end else begin
                chk("sb_no_rvalid", 32'({if_rvalid, d_rvalid}), 32'(0));
            end
            if (model_free && (if_req || d_req)) begin
                w = (if_req && d_req) ? !last_data : d_req;
                chk("sb_if_gnt", 32'(if_gnt), 32'(!w));
                chk("sb_d_gnt", 32'(d_gnt), 32'(w));
                t.is_data = w;
                if (w) begin
                    t.we = d_we; t.addr = d_addr; t.wdata = d_wdata;
                    t.len = d_len; t.uns = d_unsigned;
                end else begin
                    t.we = 0; t.addr = if_addr; t.wdata = '0; t.len = 2'b10; t.uns = 0;
                end
                txn_q.push_back(t);
                model_free = 0;
                last_data  = w;
            end else begin
                chk("sb_no_gnt", 32'({if_gnt, d_gnt}), 32'(0));
            end
            if (m_req && m_ready) begin
                if (txn_q.size() == 0 || accepted) fail_now("m_req_unexpected");
                else begin
                    chk("sb_m_we", 32'(m_we), 32'(txn_q[0].we));
                    chk("sb_m_addr", m_addr, txn_q[0].addr);
                    chk("sb_m_wdata", m_wdata, txn_q[0].wdata);
                    chk("sb_m_len", 32'(m_len), 32'(txn_q[0].len));
                    chk("sb_m_unsigned", 32'(m_unsigned), 32'(txn_q[0].uns));
                    accepted = 1;
                end
            end
            if (m_rvalid) begin
                if (!accepted) fail_now("m_rvalid_before_accept");
                pend_rv  = 1;
                accepted = 0;
            end
            if (done && !pend_rv && txn_q.size() == 0) break;
            if (cyc > 30000) begin fail_now("monitor_timeout"); break; end
        end
    endtask

    initial begin
        do_reset();
        chk("rst_m_req", 32'(m_req), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(protocol_err), 32'(0));
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);

        // Fetch only, minimum latency
        if_req = 1; if_addr = 32'h100; m_ready = 1;
        @(negedge clk); chk("f_if_gnt", 32'(if_gnt), 32'(1)); chk("f_d_gnt", 32'(d_gnt), 32'(0));
        @(posedge clk); #1 if_req = 0;
        @(negedge clk);
        chk("f_m_req", 32'(m_req), 32'(1)); chk("f_m_addr", m_addr, 32'h100);
        chk("f_m_we", 32'(m_we), 32'(0)); chk("f_m_len", 32'(m_len), 32'(2));
        chk("f_if_gnt_off", 32'(if_gnt), 32'(0));
        @(posedge clk); #1 m_ready = 0; m_rvalid = 1; m_rdata = 32'h00500093;
        @(negedge clk); chk("f_wait_m_req", 32'(m_req), 32'(0)); chk("f_early_rv", 32'(if_rvalid), 32'(0));
        @(posedge clk); #1 m_rvalid = 0;
        @(negedge clk);
        chk("f_if_rvalid", 32'(if_rvalid), 32'(1)); chk("f_if_rdata", if_rdata, 32'h00500093);
        chk("f_d_rvalid", 32'(d_rvalid), 32'(0)); chk("f_busy_idle", 32'(busy), 32'(0));
        @(negedge clk); chk("f_rvalid_pulse", 32'(if_rvalid), 32'(0));

        // Store
        @(posedge clk); #1
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_len = 2'b01; m_ready = 1;
        @(negedge clk); chk("s_d_gnt", 32'(d_gnt), 32'(1));
        @(posedge clk); #1 d_req = 0;
        @(negedge clk);
        chk("s_m_we", 32'(m_we), 32'(1)); chk("s_m_wdata", m_wdata, 32'hDEADBEEF);
        chk("s_m_len", 32'(m_len), 32'(1)); chk("s_m_addr", m_addr, 32'h2004);
        @(posedge clk); #1 m_ready = 0; m_rvalid = 1; m_rdata = 32'h0BADF00D;
        @(posedge clk); #1 m_rvalid = 0;
        @(negedge clk);
        chk("s_d_rvalid", 32'(d_rvalid), 32'(1)); chk("s_if_rvalid", 32'(if_rvalid), 32'(0));
        chk("s_if_rdata_kept", if_rdata, 32'h00500093);
        @(negedge clk); chk("s_rvalid_pulse", 32'(d_rvalid), 32'(0));

        // Spurious response while idle
        @(posedge clk); #1 m_rvalid = 1; m_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1 m_rvalid = 0;
        @(negedge clk);
        chk("sp_err", 32'(protocol_err), 32'(1));
        chk("sp_rvalid", 32'({if_rvalid, d_rvalid}), 32'(0));
        chk("sp_if_rdata", if_rdata, 32'h00500093); chk("sp_d_rdata", d_rdata, 32'h0BADF00D);
        @(posedge clk); #1;
        do_reset();
        chk("sp_err_cleared", 32'(protocol_err), 32'(0));

        // Back-pressure, fetch held off, back-to-back grant on the completion cycle
        d_req = 1; d_we = 0; d_addr = 32'h2008; d_len = 2'b10; d_unsigned = 1; m_ready = 0;
        @(negedge clk); chk("bp_d_gnt", 32'(d_gnt), 32'(1));
        @(posedge clk); #1 d_req = 0; if_req = 1; if_addr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_m_req", 32'(m_req), 32'(1)); chk("bp_m_addr", m_addr, 32'h2008);
            chk("bp_m_unsigned", 32'(m_unsigned), 32'(1));
            chk("bp_hold", 32'({if_gnt, d_gnt}), 32'(0));
            @(posedge clk); #1 m_ready = (k == 2);
        end
        m_rvalid = 1; m_rdata = 32'h11223344;
        @(negedge clk); chk("bp_wait", 32'(m_req), 32'(0)); chk("bp_wait_hold", 32'(if_gnt), 32'(0));
        @(posedge clk); #1 m_rvalid = 0;
        @(negedge clk);
        chk("bp_d_rvalid", 32'(d_rvalid), 32'(1)); chk("bp_d_rdata", d_rdata, 32'h11223344);
        chk("bp_b2b_gnt", 32'(if_gnt), 32'(1));
        @(posedge clk); #1 if_req = 0; m_ready = 1;
        @(negedge clk); chk("bp_f_addr", m_addr, 32'h300);
        @(posedge clk); #1 m_ready = 0; m_rvalid = 1; m_rdata = 32'hCAFE0001;
        @(posedge clk); #1 m_rvalid = 0;
        @(negedge clk);
        chk("bp_if_rvalid", 32'(if_rvalid), 32'(1)); chk("bp_if_rdata", if_rdata, 32'hCAFE0001);

        // Conflict from reset release: strict alternation starting with fetch
        @(posedge clk); #1;
        reset = 0; if_req = 1; d_req = 1; if_addr = 32'h400; d_addr = 32'h800;
        d_we = 0; m_ready = 1; m_rvalid = 0;
        @(posedge clk); #1 reset = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cf_if_gnt", 32'(if_gnt), 32'(k % 2 == 0));
            chk("cf_d_gnt", 32'(d_gnt), 32'(k % 2 == 1));
            chk("cf_busy_low", 32'(busy), 32'(0));
            @(posedge clk); #1;
            @(negedge clk);
            chk("cf_busy_issue", 32'(busy), 32'(1));
            chk("cf_m_addr", m_addr, (k % 2 == 0) ? 32'h400 : 32'h800);
            chk("cf_hold", 32'({if_gnt, d_gnt}), 32'(0));
            @(posedge clk); #1 m_rvalid = 1; m_rdata = 32'(k);
            @(negedge clk); chk("cf_busy_wait", 32'(busy), 32'(1));
            @(posedge clk); #1 m_rvalid = 0;
        end
        if_req = 0; d_req = 0;
        @(negedge clk); chk("cf_last_d_rvalid", 32'(d_rvalid), 32'(1));

        // Reset while waiting on a load, then a late response
        @(posedge clk); #1;
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h3000; m_ready = 1;
        @(negedge clk); chk("rw_d_gnt", 32'(d_gnt), 32'(1));
        @(posedge clk); #1 d_req = 0;
        @(negedge clk); chk("rw_m_req", 32'(m_req), 32'(1));
        @(posedge clk); #1 m_ready = 0;
        @(negedge clk); chk("rw_busy", 32'(busy), 32'(1));
        #2 reset = 0;
        #1;
        chk("rw_m_req_clr", 32'(m_req), 32'(0)); chk("rw_busy_clr", 32'(busy), 32'(0));
        chk("rw_no_rvalid", 32'(d_rvalid), 32'(0));
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 m_rvalid = 1; m_rdata = 32'h55;
        @(posedge clk); #1 m_rvalid = 0;
        @(negedge clk);
        chk("rw_late_err", 32'(protocol_err), 32'(1)); chk("rw_late_rvalid", 32'(d_rvalid), 32'(0));
        chk("rw_d_rdata", d_rdata, 32'h0);
        repeat (3) begin @(negedge clk); chk("rw_err_sticky", 32'(protocol_err), 32'(1)); end

        // Randomized traffic through the scoreboard
        @(posedge clk); #1;
        do_reset();
        done = 0;
        fork
            begin
                fork
                    gen_fetch(60);
                    gen_data(60);
                    responder(120);
                join
                done = 1;
            end
            monitor();
        join
        chk("rand_txn_q_empty", 32'(txn_q.size()), 32'(0));
        chk("rand_no_err", 32'(protocol_err), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the core's instruction-fetch requester and its load/store requester.
- Sits between the core (fetch controller, memory access control) and the unified memory model/SRAM wrapper.
- Round-robin arbitration, one outstanding transaction at a time, registered request capture, response routed back to its owner.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse, fetch data valid.
- if_rdata  out  DATA_WIDTH  fetch data, held until next fetch completion.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_len  in  2  access length code, passed through unchanged.
- d_unsigned  in  1  load zero-extend flag, passed through unchanged.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse, load data valid or store complete.
- d_rdata  out  DATA_WIDTH  load data, held until next data completion.
- m_req  out  1  memory request.
- m_we, m_addr, m_wdata, m_len, m_unsigned  out  1/ADDR_WIDTH/DATA_WIDTH/2/1  latched request fields.
- m_ready  in  1  memory accepts m_req this cycle.
- m_rvalid  in  1  memory response (every transaction, writes included).
- m_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  state != IDLE.
- protocol_err  out  1  sticky: unexpected m_rvalid.

Behaviour:
- Reset (asynchronous, reset==0):
  - State goes to IDLE and last_owner goes to DATA.
  - m_req, if_gnt, d_gnt, if_rvalid, d_rvalid, busy and protocol_err all clear to 0.
  - if_rdata, d_rdata and all latched m_* fields clear to 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If exactly one request is asserted, select it.
  - If both are asserted, select the owner != last_owner.
  - The selected gnt is asserted combinationally in that cycle.
  - On the clock edge: latch fields (fetch sets m_we=0, m_wdata=0, m_len=2'b10, m_unsigned=0), record owner, set last_owner=owner, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - m_req=1 with the latched fields, stable until accepted.
  - m_ready=1 -> go to WAIT; m_ready=0 -> stay in ISSUE.
  - No gnt is asserted.
- WAIT:
  - m_req=0.
  - On m_rvalid: register m_rdata into the owner's rdata (d_rdata is updated for stores too, value undefined but registered), pulse the owner's rvalid the following cycle, go to IDLE.
  - Response latency to the requester is the m_rvalid cycle + 1.
- Minimum round trip, both counted in cycles after the gnt cycle:
  - m_ready=1 immediately: m_req at +1, WAIT at +2.
  - Earliest m_rvalid at +2, rvalid at +3.
- Back-to-back operation:
  - A new gnt is possible in the same cycle the previous rvalid pulses, because the state is already IDLE.
  - Requests arriving during ISSUE/WAIT are held off (gnt=0) and never dropped; the requester keeps req high.
- Simultaneous events:
  - m_ready and m_rvalid in ISSUE: m_rvalid is ignored and protocol_err is set.
  - m_rvalid in IDLE or ISSUE sets protocol_err. It stays set until reset.
- Fairness: under continuous dual requests, grants alternate strictly. Neither owner waits more than one transaction.
- Reset mid-transaction: the transaction is aborted immediately with no rvalid pulse. A late m_rvalid arriving after reset release flags protocol_err.
- The arbiter never modifies address, data, length or signedness; it only passes them through.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, m_ready=1 at once, m_rvalid two cycles later with m_rdata=0x00500093 -> if_gnt one cycle, m_addr=0x100, m_we=0, if_rvalid pulse one cycle after m_rvalid, if_rdata=0x00500093, d_rvalid=0.
- Conflict after reset: if_req and d_req both high from reset release, four transactions -> grant order fetch, data, fetch, data; busy low only one cycle between transactions.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_len=2'b01 -> m_we=1, m_wdata=0xDEADBEEF, m_len=2'b01, d_rvalid pulse after m_rvalid, if_rvalid=0.
- Back-pressure: m_ready low for 3 cycles in ISSUE -> m_req and m_addr stable all 4 cycles, WAIT entered only after m_ready=1, no extra gnt.
- Reset mid-WAIT: assert reset=0 while waiting for a data load -> m_req=0, busy=0, no d_rvalid; after release, m_rvalid=1 -> protocol_err=1, held until the next reset.
- Spurious response: m_rvalid=1 in IDLE with no traffic -> protocol_err=1, if_rvalid=d_rvalid=0, rdata outputs unchanged.
